// File: rtl/rs_gen.sv
// Reservation station for ALU/branch micro-ops. Captures CDB results and issues one ready entry per
// cycle. `RS_OLDEST_FIRST_EN` selects oldest-ready issue through an age matrix; otherwise lowest index.
module rs_gen #(
  parameter int unsigned RS_DEPTH = 16,
  parameter int unsigned CDB_N    = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ROB_W    = 4,
  parameter int unsigned OP_W     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic                        dsp_valid,
  input  logic [OP_W-1:0]             dsp_openum,
  input  logic [DATA_W-1:0]           dsp_v1,
  input  logic [DATA_W-1:0]           dsp_v2,
  input  logic [ROB_W-1:0]            dsp_q1,
  input  logic [ROB_W-1:0]            dsp_q2,
  input  logic [DATA_W-1:0]           dsp_pc,
  input  logic [DATA_W-1:0]           dsp_imm,
  input  logic [ROB_W-1:0]            dsp_rob_id,
  output logic                        full,
  output logic [$clog2(RS_DEPTH):0]   used_cnt,
  input  logic [CDB_N-1:0]            cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]      cdb_rob_id,
  input  logic [CDB_N*DATA_W-1:0]     cdb_result,
  output logic                        ex_valid,
  input  logic                        ex_ready,
  output logic [OP_W-1:0]             ex_openum,
  output logic [DATA_W-1:0]           ex_v1,
  output logic [DATA_W-1:0]           ex_v2,
  output logic [DATA_W-1:0]           ex_pc,
  output logic [DATA_W-1:0]           ex_imm,
  output logic [ROB_W-1:0]            ex_rob_id
);

  localparam int unsigned IdxW = $clog2(RS_DEPTH);
  localparam int unsigned CntW = $clog2(RS_DEPTH) + 1;

  // Entry storage
  logic [RS_DEPTH-1:0] r_busy;
  logic [OP_W-1:0]     r_op   [RS_DEPTH];
  logic [DATA_W-1:0]   r_v1   [RS_DEPTH];
  logic [DATA_W-1:0]   r_v2   [RS_DEPTH];
  logic [ROB_W-1:0]    r_q1   [RS_DEPTH];
  logic [ROB_W-1:0]    r_q2   [RS_DEPTH];
  logic [DATA_W-1:0]   r_pc   [RS_DEPTH];
  logic [DATA_W-1:0]   r_imm  [RS_DEPTH];
  logic [ROB_W-1:0]    r_rob  [RS_DEPTH];
`ifdef RS_OLDEST_FIRST_EN
  // r_age[i][j] set: entry j is older than entry i
  logic [RS_DEPTH-1:0] r_age  [RS_DEPTH];
`endif

  logic [CntW-1:0]     r_used_cnt;
  logic                r_ex_valid;
  logic [OP_W-1:0]     r_ex_op;
  logic [DATA_W-1:0]   r_ex_v1;
  logic [DATA_W-1:0]   r_ex_v2;
  logic [DATA_W-1:0]   r_ex_pc;
  logic [DATA_W-1:0]   r_ex_imm;
  logic [ROB_W-1:0]    r_ex_rob;

  logic [ROB_W-1:0]    w_q1_nxt [RS_DEPTH];
  logic [ROB_W-1:0]    w_q2_nxt [RS_DEPTH];
  logic [DATA_W-1:0]   w_v1_nxt [RS_DEPTH];
  logic [DATA_W-1:0]   w_v2_nxt [RS_DEPTH];
  logic [ROB_W-1:0]    w_dsp_q1;
  logic [ROB_W-1:0]    w_dsp_q2;
  logic [DATA_W-1:0]   w_dsp_v1;
  logic [DATA_W-1:0]   w_dsp_v2;
  logic [RS_DEPTH-1:0] w_ready;
  logic [RS_DEPTH-1:0] w_cand;
  logic [IdxW-1:0]     w_iss_idx;
  logic [IdxW-1:0]     w_free_idx;
  logic                w_any_ready;
  logic                w_full;
  logic                w_ins;
  logic                w_iss;

  // CDB wakeup of stored entries; the descending loop lets the lowest bus win
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_q1_nxt[i] = r_q1[i];
      w_q2_nxt[i] = r_q2[i];
      w_v1_nxt[i] = r_v1[i];
      w_v2_nxt[i] = r_v2[i];
      for (int k = CDB_N - 1; k >= 0; k--) begin
        if (cdb_valid[k] && (r_q1[i] != '0) && (cdb_rob_id[k*ROB_W +: ROB_W] == r_q1[i])) begin
          w_q1_nxt[i] = '0;
          w_v1_nxt[i] = cdb_result[k*DATA_W +: DATA_W];
        end
        if (cdb_valid[k] && (r_q2[i] != '0) && (cdb_rob_id[k*ROB_W +: ROB_W] == r_q2[i])) begin
          w_q2_nxt[i] = '0;
          w_v2_nxt[i] = cdb_result[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Insert-time bypass of the dispatched operands
  always_comb begin
    w_dsp_q1 = dsp_q1;
    w_dsp_q2 = dsp_q2;
    w_dsp_v1 = dsp_v1;
    w_dsp_v2 = dsp_v2;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (dsp_q1 != '0) && (cdb_rob_id[k*ROB_W +: ROB_W] == dsp_q1)) begin
        w_dsp_q1 = '0;
        w_dsp_v1 = cdb_result[k*DATA_W +: DATA_W];
      end
      if (cdb_valid[k] && (dsp_q2 != '0) && (cdb_rob_id[k*ROB_W +: ROB_W] == dsp_q2)) begin
        w_dsp_q2 = '0;
        w_dsp_v2 = cdb_result[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_cand[i] = w_ready[i] && ((r_age[i] & w_ready) == '0);
    end
  end
`else
  assign w_cand = w_ready;
`endif

  always_comb begin
    w_iss_idx  = '0;
    w_free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (w_cand[i]) w_iss_idx = IdxW'(i);
      if (!r_busy[i]) w_free_idx = IdxW'(i);
    end
  end

  assign w_any_ready = |w_ready;
  assign w_full      = &r_busy;
  assign w_ins       = dsp_valid && !w_full;
  assign w_iss       = w_any_ready && (!r_ex_valid || ex_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_used_cnt <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_v1    <= '0;
      r_ex_v2    <= '0;
      r_ex_pc    <= '0;
      r_ex_imm   <= '0;
      r_ex_rob   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_op[i]  <= '0;
        r_v1[i]  <= '0;
        r_v2[i]  <= '0;
        r_q1[i]  <= '0;
        r_q2[i]  <= '0;
        r_pc[i]  <= '0;
        r_imm[i] <= '0;
        r_rob[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
        r_age[i] <= '0;
`endif
      end
    end else if (flush) begin
      r_busy     <= '0;
      r_used_cnt <= '0;
      r_ex_valid <= 1'b0;
`ifdef RS_OLDEST_FIRST_EN
      for (int i = 0; i < RS_DEPTH; i++) r_age[i] <= '0;
`endif
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_q1[i] <= w_q1_nxt[i];
        r_q2[i] <= w_q2_nxt[i];
        r_v1[i] <= w_v1_nxt[i];
        r_v2[i] <= w_v2_nxt[i];
      end

      if (w_iss) begin
        r_busy[w_iss_idx] <= 1'b0;
        r_ex_valid        <= 1'b1;
        r_ex_op           <= r_op[w_iss_idx];
        r_ex_v1           <= r_v1[w_iss_idx];
        r_ex_v2           <= r_v2[w_iss_idx];
        r_ex_pc           <= r_pc[w_iss_idx];
        r_ex_imm          <= r_imm[w_iss_idx];
        r_ex_rob          <= r_rob[w_iss_idx];
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
        r_ex_op    <= '0;
      end

      if (w_ins) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= dsp_openum;
        r_v1[w_free_idx]   <= w_dsp_v1;
        r_v2[w_free_idx]   <= w_dsp_v2;
        r_q1[w_free_idx]   <= w_dsp_q1;
        r_q2[w_free_idx]   <= w_dsp_q2;
        r_pc[w_free_idx]   <= dsp_pc;
        r_imm[w_free_idx]  <= dsp_imm;
        r_rob[w_free_idx]  <= dsp_rob_id;
`ifdef RS_OLDEST_FIRST_EN
        // New entry is younger than every survivor; nobody is younger than it yet
        for (int j = 0; j < RS_DEPTH; j++) begin
          r_age[j][w_free_idx] <= 1'b0;
          r_age[w_free_idx][j] <= r_busy[j] && !(w_iss && (w_iss_idx == IdxW'(j)));
        end
`endif
      end

      r_used_cnt <= r_used_cnt + CntW'(w_ins) - CntW'(w_iss);
    end
  end

`ifdef RS_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst && !flush && rdy && dsp_valid && w_full) begin
      $error("rs_gen: dispatch dropped while station full");
    end
  end
`endif

  assign full      = w_full;
  assign used_cnt  = r_used_cnt;
  assign ex_valid  = r_ex_valid;
  assign ex_openum = r_ex_op;
  assign ex_v1     = r_ex_v1;
  assign ex_v2     = r_ex_v2;
  assign ex_pc     = r_ex_pc;
  assign ex_imm    = r_ex_imm;
  assign ex_rob_id = r_ex_rob;

endmodule
